iter_divider: RTL and testbench
===============================

// Module: iter_divider
// PURPOSE
//   Multi-cycle radix-2 restoring divider for the EXE stage (MIPS DIV/DIVU).
//   Produces quotient (LO) and remainder (HI).
//   Drives o_busy, which feeds the pipeline controller's i_div_busy input and freezes all stage enables.
//   Accepts a flush (i_cancel) from MEM-stage exception handling.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; legal values are >= 4
//   CNT_W  6   iteration counter width; must satisfy CNT_W >= clog2(WIDTH+1)
// PORTS
//   clk            in   1      single clock; all state updates on posedge
//   reset          in   1      synchronous, active-high
//   i_start        in   1      launch a divide; sampled in IDLE or DONE only
//   i_signed       in   1      1 = DIV (two's complement), 0 = DIVU
//   i_dividend     in   WIDTH  numerator, sampled with i_start
//   i_divisor      in   WIDTH  denominator, sampled with i_start
//   i_cancel       in   1      flush; aborts any operation in flight
//   o_busy         out  1      stall request to the pipeline controller
//   o_done         out  1      one-cycle pulse when results are valid
//   o_quotient     out  WIDTH  quotient (LO)
//   o_remainder    out  WIDTH  remainder (HI)
//   o_div_by_zero  out  1      last completed operation had divisor == 0
// BEHAVIOUR
//   - States: IDLE, CALC, DONE.
//   - Reset: state = IDLE; counter = 0; all outputs 0.
//   - o_busy = (state==CALC) | ((state==IDLE | state==DONE) & i_start & ~i_cancel).
//     o_busy is combinational so the pipeline stalls in the launch cycle itself.
//   - Launch (cycle 0, i_start=1 in IDLE or DONE):
//     - latch |dividend| and |divisor| (magnitudes only when i_signed=1);
//     - latch sign_q = sign(dividend) ^ sign(divisor) and sign_r = sign(dividend);
//     - clear the partial remainder; go to CALC with count = 0.
//   - CALC: one iteration per cycle.
//     - rem = {rem, q_msb} - divisor; if the result is non-negative keep it and shift in 1, else shift in 0.
//     - After WIDTH iterations (posedge ending cycle WIDTH): apply sign fix, register results, go to DONE.
//   - Latency: o_busy is high for cycles 0..WIDTH (WIDTH+1 cycles). In cycle WIDTH+1, o_done=1, o_busy=0 and results are valid.
//   - DONE -> IDLE after one cycle unless i_start relaunches. Results are held until the next completion.
//   - i_start during CALC is ignored.
//   - Sign fix: negate the quotient if sign_q; negate the remainder if sign_r.
//     The remainder always takes the dividend's sign.
//   - Divide by zero: o_quotient = all ones, o_remainder = original dividend, o_div_by_zero = 1.
//     Same result for signed and unsigned.
//   - Overflow: MIN_INT / -1 (signed) gives quotient 0x8000_0000 and remainder 0. No flag is raised.
//   - i_cancel has priority over i_start and CALC: next state = IDLE, o_done does not pulse, results are unchanged.
//     i_cancel together with i_start in the same cycle means no launch.
//   - Reset has priority over everything, including mid-operation.
// CONFIGURATION
//   - DIV_EARLY_OUT_EN defined: at launch, if divisor==0 or dividend==0, skip CALC and go straight to DONE.
//     o_busy is high in cycle 0 only; o_done pulses in cycle 1 with the same results as above.
//   - DIV_EARLY_OUT_EN undefined: every operation takes the full WIDTH+1-cycle latency, including the zero cases.
// STRUCTURE
//   - Shared package/header holds:
//     - state encodings: IDLE=2'd0, CALC=2'd1, DONE=2'd2;
//     - the DIV_BY_ZERO_Q constant (all ones).
//   - Sub-module div_step: purely combinational single restoring iteration.
//     (rem_in, q_in, divisor) -> (rem_out, q_out). Instantiated once in the top module.
//   - The top module holds the FSM, counter, operand/sign registers and the sign-fix negators.
// TESTING
//   - DIVU 100 / 7: o_busy high for exactly 33 cycles; then o_done=1, q=14, r=2.
//   - DIV -7 / 2: q=0xFFFF_FFFD (-3), r=0xFFFF_FFFF (-1). DIV 7 / -2: q=-3, r=1.
//   - DIV 0x8000_0000 / 0xFFFF_FFFF: q=0x8000_0000, r=0, o_div_by_zero=0.
//   - DIVU 5 / 0: q=0xFFFF_FFFF, r=5, o_div_by_zero=1. Latency is 33 cycles, or 1 cycle with DIV_EARLY_OUT_EN.
//   - i_cancel at cycle 10 of CALC: state IDLE next cycle, o_busy=0, no o_done, outputs keep prior values.
//     A new launch then completes normally.
//   - reset asserted mid-CALC: all outputs 0 next cycle. i_start during CALC has no effect on the result.
//     Back-to-back launch in DONE: second result after a further 33 cycles.

Source files
------------

// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and
// the divide-by-zero quotient pattern.
package iter_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // All-ones quotient returned on divide by zero; slice to the operand width.
   localparam logic [127:0] DIV_BY_ZERO_Q = {128{1'b1}};

endpackage

// File: rtl/iter_divider_div_step.sv
// One restoring-division iteration: shift the next quotient bit into the
// partial remainder, trial-subtract the divisor and keep or restore.
module iter_divider_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] q_out
);

   // The shifted remainder is below twice the divisor, so WIDTH+1 bits hold
   // the trial difference with its sign in the top bit.
   logic [WIDTH:0] trial_s;

   // Trial subtraction and keep/restore decision
   always_comb begin
      trial_s = {rem_in, q_in[WIDTH-1]} - {1'b0, divisor};
      if (trial_s[WIDTH] == 1'b0) begin
         rem_out = trial_s[WIDTH-1:0];
         q_out   = {q_in[WIDTH-2:0], 1'b1};
      end else begin
         rem_out = {rem_in[WIDTH-2:0], q_in[WIDTH-1]};
         q_out   = {q_in[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider (MIPS DIV/DIVU) producing quotient
// (LO) and remainder (HI). o_busy stalls the pipeline from the launch cycle.
// Optional feature macro DIV_EARLY_OUT_EN: zero dividend or zero divisor
// finishes one cycle after launch instead of running all iterations.
module iter_divider
   import iter_divider_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic             i_signed,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   input  logic             i_cancel,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_by_zero
);

   localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t           state_r;
   logic [CNT_W-1:0] count_r;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] quo_r;        // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dvs_r;
   logic [WIDTH-1:0] orig_dvd_r;
   logic             sign_q_r;
   logic             sign_r_r;
   logic [WIDTH-1:0] quotient_r;
   logic [WIDTH-1:0] remainder_r;
   logic             done_r;
   logic             dbz_r;

   logic             launch_s;
   logic             dvd_neg_s;
   logic             dvs_neg_s;
   logic [WIDTH-1:0] dvd_mag_s;
   logic [WIDTH-1:0] dvs_mag_s;
   logic [WIDTH-1:0] rem_next_s;
   logic [WIDTH-1:0] quo_next_s;
   logic [WIDTH-1:0] fin_q_s;
   logic [WIDTH-1:0] fin_r_s;
   logic             fin_dbz_s;

   assign launch_s      = ((state_r == IDLE) | (state_r == DONE)) & i_start & ~i_cancel;
   assign o_busy        = (state_r == CALC) | launch_s;
   assign o_done        = done_r;
   assign o_quotient    = quotient_r;
   assign o_remainder   = remainder_r;
   assign o_div_by_zero = dbz_r;

   iter_divider_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_r),
      .q_in    (quo_r),
      .divisor (dvs_r),
      .rem_out (rem_next_s),
      .q_out   (quo_next_s)
   );

   // Operand signs and magnitudes; DIVU treats both operands as unsigned
   always_comb begin
      dvd_neg_s = i_signed & i_dividend[WIDTH-1];
      dvs_neg_s = i_signed & i_divisor[WIDTH-1];
      if (dvd_neg_s) begin
         dvd_mag_s = ~i_dividend + ONE;
      end else begin
         dvd_mag_s = i_dividend;
      end
      if (dvs_neg_s) begin
         dvs_mag_s = ~i_divisor + ONE;
      end else begin
         dvs_mag_s = i_divisor;
      end
   end

   // Final results from the last iteration, with sign fix and zero-divisor override
   always_comb begin
      if (dvs_r == ZERO) begin
         fin_q_s   = DIV_BY_ZERO_Q[WIDTH-1:0];
         fin_r_s   = orig_dvd_r;
         fin_dbz_s = 1'b1;
      end else begin
         fin_dbz_s = 1'b0;
         if (sign_q_r) begin
            fin_q_s = ~quo_next_s + ONE;
         end else begin
            fin_q_s = quo_next_s;
         end
         if (sign_r_r) begin
            fin_r_s = ~rem_next_s + ONE;
         end else begin
            fin_r_s = rem_next_s;
         end
      end
   end

   // Divider FSM, iteration datapath and registered results
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         count_r     <= CNT_ZERO;
         rem_r       <= ZERO;
         quo_r       <= ZERO;
         dvs_r       <= ZERO;
         orig_dvd_r  <= ZERO;
         sign_q_r    <= 1'b0;
         sign_r_r    <= 1'b0;
         quotient_r  <= ZERO;
         remainder_r <= ZERO;
         done_r      <= 1'b0;
         dbz_r       <= 1'b0;
      end else if (i_cancel) begin
         state_r <= IDLE;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               done_r <= 1'b0;
               if (i_start) begin
                  rem_r      <= ZERO;
                  quo_r      <= dvd_mag_s;
                  dvs_r      <= dvs_mag_s;
                  orig_dvd_r <= i_dividend;
                  sign_q_r   <= dvd_neg_s ^ dvs_neg_s;
                  sign_r_r   <= dvd_neg_s;
                  count_r    <= CNT_ZERO;
`ifdef DIV_EARLY_OUT_EN
                  if ((i_divisor == ZERO) || (i_dividend == ZERO)) begin
                     state_r <= DONE;
                     done_r  <= 1'b1;
                     if (i_divisor == ZERO) begin
                        quotient_r  <= DIV_BY_ZERO_Q[WIDTH-1:0];
                        remainder_r <= i_dividend;
                        dbz_r       <= 1'b1;
                     end else begin
                        quotient_r  <= ZERO;
                        remainder_r <= ZERO;
                        dbz_r       <= 1'b0;
                     end
                  end else begin
                     state_r <= CALC;
                  end
`else
                  state_r <= CALC;
`endif
               end else begin
                  state_r <= IDLE;
               end
            end
            CALC: begin
               rem_r   <= rem_next_s;
               quo_r   <= quo_next_s;
               count_r <= count_r + CNT_ONE;
               if (count_r == LAST_ITER) begin
                  state_r     <= DONE;
                  done_r      <= 1'b1;
                  quotient_r  <= fin_q_s;
                  remainder_r <= fin_r_s;
                  dbz_r       <= fin_dbz_s;
               end else begin
                  state_r <= CALC;
               end
            end
            default: begin
               state_r <= IDLE;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider (WIDTH=32). Honours the
// DIV_EARLY_OUT_EN macro when computing the expected zero-operand latency.
module tb_iter_divider;

   logic        clk;
   logic        reset;
   logic        i_start;
   logic        i_signed;
   logic [31:0] i_dividend;
   logic [31:0] i_divisor;
   logic        i_cancel;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_quotient;
   logic [31:0] o_remainder;
   logic        o_div_by_zero;

   int checks = 0;
   int errors = 0;

`ifdef DIV_EARLY_OUT_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 33;
`endif

   iter_divider #(.WIDTH(32), .CNT_W(6)) dut (
      .clk           (clk),
      .reset         (reset),
      .i_start       (i_start),
      .i_signed      (i_signed),
      .i_dividend    (i_dividend),
      .i_divisor     (i_divisor),
      .i_cancel      (i_cancel),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_quotient    (o_quotient),
      .o_remainder   (o_remainder),
      .o_div_by_zero (o_div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch one divide at the current negedge and count busy cycles until it drops.
   // inj > 0 re-pulses i_start with other operands that many cycles after launch.
   task automatic do_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input int inj, output int nbusy, output logic seen_done);
      i_signed = sg; i_dividend = a; i_divisor = b; i_start = 1'b1;
      nbusy = 0; seen_done = 1'b0;
      #1;
      for (int k = 0; k < 100; k++) begin
         if (o_busy) nbusy++;
         else begin
            seen_done = o_done;
            break;
         end
         @(negedge clk);
         if (k + 1 == inj) begin
            i_start = 1'b1; i_dividend = 32'd9; i_divisor = 32'd3;
         end else begin
            i_start = 1'b0;
         end
         #1;
      end
      i_start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; i_start = 1'b0; i_signed = 1'b0; i_cancel = 1'b0;
      i_dividend = 32'd0; i_divisor = 32'd0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
      checks++; if (o_quotient !== 32'd0) begin errors++; $display("FAIL reset_q got %h want 0", o_quotient); end
      checks++; if (o_remainder !== 32'd0) begin errors++; $display("FAIL reset_r got %h want 0", o_remainder); end
      checks++; if (o_div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", o_div_by_zero); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_unsigned();
      int nb; logic dn;
      do_op(1'b0, 32'd100, 32'd7, 0, nb, dn);
      checks++; if (nb !== 33) begin errors++; $display("FAIL divu_latency got %0d want 33", nb); end
      checks++; if (dn !== 1'b1) begin errors++; $display("FAIL divu_done got %b want 1", dn); end
      checks++; if (o_quotient !== 32'd14) begin errors++; $display("FAIL divu_q got %h want e", o_quotient); end
      checks++; if (o_remainder !== 32'd2) begin errors++; $display("FAIL divu_r got %h want 2", o_remainder); end
      checks++; if (o_div_by_zero !== 1'b0) begin errors++; $display("FAIL divu_dbz got %b want 0", o_div_by_zero); end
      @(negedge clk); #1;
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b want 0", o_done); end
      checks++; if (o_quotient !== 32'd14) begin errors++; $display("FAIL hold_q got %h want e", o_quotient); end
      @(negedge clk);
      do_op(1'b0, 32'hFFFF_FFF9, 32'd2, 0, nb, dn);
      checks++; if ({o_quotient, o_remainder} !== {32'h7FFF_FFFC, 32'd1}) begin
         errors++; $display("FAIL divu_big got %h/%h want 7ffffffc/1", o_quotient, o_remainder); end
      @(negedge clk);
   endtask

   task automatic test_signed();
      int nb; logic dn;
      do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, nb, dn);
      checks++; if ({dn, o_quotient, o_remainder} !== {1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin
         errors++; $display("FAIL div_m7_2 got %b %h/%h want 1 fffffffd/ffffffff", dn, o_quotient, o_remainder); end
      @(negedge clk);
      do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, nb, dn);
      checks++; if ({o_quotient, o_remainder} !== {32'hFFFF_FFFD, 32'd1}) begin
         errors++; $display("FAIL div_7_m2 got %h/%h want fffffffd/1", o_quotient, o_remainder); end
      @(negedge clk);
      do_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, nb, dn);
      checks++; if ({o_quotient, o_remainder} !== {32'd3, 32'hFFFF_FFFF}) begin
         errors++; $display("FAIL div_m7_m2 got %h/%h want 3/ffffffff", o_quotient, o_remainder); end
      @(negedge clk);
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, nb, dn);
      checks++; if ({o_quotient, o_remainder, o_div_by_zero} !== {32'h8000_0000, 32'd0, 1'b0}) begin
         errors++; $display("FAIL div_overflow got %h/%h dbz %b want 80000000/0 dbz 0", o_quotient, o_remainder, o_div_by_zero); end
      @(negedge clk);
   endtask

   task automatic test_div_by_zero();
      int nb; logic dn;
      do_op(1'b0, 32'd5, 32'd0, 0, nb, dn);
      checks++; if (nb !== ZLAT) begin errors++; $display("FAIL dbz_latency got %0d want %0d", nb, ZLAT); end
      checks++; if ({dn, o_quotient, o_remainder, o_div_by_zero} !== {1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1}) begin
         errors++; $display("FAIL divu_dbz got %b %h/%h dbz %b want 1 ffffffff/5 dbz 1", dn, o_quotient, o_remainder, o_div_by_zero); end
      @(negedge clk);
      do_op(1'b1, 32'hFFFF_FFFB, 32'd0, 0, nb, dn);
      checks++; if ({o_quotient, o_remainder, o_div_by_zero} !== {32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1}) begin
         errors++; $display("FAIL div_dbz got %h/%h dbz %b want ffffffff/fffffffb dbz 1", o_quotient, o_remainder, o_div_by_zero); end
      @(negedge clk);
      do_op(1'b0, 32'd0, 32'd9, 0, nb, dn);
      checks++; if ({nb, dn, o_quotient, o_remainder, o_div_by_zero} !== {ZLAT, 1'b1, 32'd0, 32'd0, 1'b0}) begin
         errors++; $display("FAIL zero_dvd got lat %0d %b %h/%h dbz %b want lat %0d", nb, dn, o_quotient, o_remainder, o_div_by_zero, ZLAT); end
      @(negedge clk);
   endtask

   task automatic test_cancel();
      int nb; logic dn; logic seen;
      do_op(1'b0, 32'd1000, 32'd10, 0, nb, dn);
      @(negedge clk);
      i_signed = 1'b0; i_dividend = 32'd100; i_divisor = 32'd7; i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      repeat (9) @(negedge clk);
      i_cancel = 1'b1;
      @(negedge clk); i_cancel = 1'b0; #1;
      checks++; if ({o_busy, o_done} !== 2'b00) begin errors++; $display("FAIL cancel_idle got busy %b done %b want 0 0", o_busy, o_done); end
      checks++; if ({o_quotient, o_remainder} !== {32'd100, 32'd0}) begin
         errors++; $display("FAIL cancel_hold got %h/%h want 64/0", o_quotient, o_remainder); end
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk); #1;
         if (o_done || o_busy) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL cancel_no_done got activity %b want 0", seen); end
      i_start = 1'b1; i_cancel = 1'b1; #1;
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL cancel_start_busy got %b want 0", o_busy); end
      @(negedge clk); i_start = 1'b0; i_cancel = 1'b0; #1;
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL cancel_start_nolaunch got %b want 0", o_busy); end
      @(negedge clk);
      do_op(1'b0, 32'd45, 32'd6, 0, nb, dn);
      checks++; if ({nb, dn, o_quotient, o_remainder} !== {33, 1'b1, 32'd7, 32'd3}) begin
         errors++; $display("FAIL relaunch got lat %0d %b %h/%h want 33 1 7/3", nb, dn, o_quotient, o_remainder); end
      @(negedge clk);
   endtask

   task automatic test_start_during_calc();
      int nb; logic dn;
      do_op(1'b0, 32'd100, 32'd7, 5, nb, dn);
      checks++; if ({nb, dn, o_quotient, o_remainder} !== {33, 1'b1, 32'd14, 32'd2}) begin
         errors++; $display("FAIL start_in_calc got lat %0d %b %h/%h want 33 1 e/2", nb, dn, o_quotient, o_remainder); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int nb; logic dn;
      do_op(1'b0, 32'd45, 32'd6, 0, nb, dn);
      do_op(1'b0, 32'd1000, 32'd7, 0, nb, dn);
      checks++; if ({nb, dn, o_quotient, o_remainder} !== {33, 1'b1, 32'd142, 32'd6}) begin
         errors++; $display("FAIL back_to_back got lat %0d %b %h/%h want 33 1 8e/6", nb, dn, o_quotient, o_remainder); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int nb; logic dn;
      i_signed = 1'b0; i_dividend = 32'd100; i_divisor = 32'd7; i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk); #1;
      checks++; if ({o_busy, o_done, o_quotient, o_remainder, o_div_by_zero} !== {2'b00, 32'd0, 32'd0, 1'b0}) begin
         errors++; $display("FAIL reset_mid got busy %b done %b %h/%h dbz %b want all 0", o_busy, o_done, o_quotient, o_remainder, o_div_by_zero); end
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      do_op(1'b0, 32'd100, 32'd7, 0, nb, dn);
      checks++; if ({nb, dn, o_quotient, o_remainder} !== {33, 1'b1, 32'd14, 32'd2}) begin
         errors++; $display("FAIL after_reset got lat %0d %b %h/%h want 33 1 e/2", nb, dn, o_quotient, o_remainder); end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_by_zero();
      test_cancel();
      test_start_during_calc();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
